star_collect_ctrl: RTL and testbench

//   Consumes the sticky touch flags from the star pickup modules (star1..starN) and turns them into game score.

---
 rtl/star_collect_ctrl.sv | 142 ++++++++++++++
 tb/tb_star_collect_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/star_collect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : star_collect_ctrl
//  Description : Turns sticky star touch flags into BCD score, a collected-star
//                count, a commit strobe and a stretched pickup sound gate.
//                New touches are serialised lowest index first, one star per
//                six clock cycles, through a four-step BCD digit adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module star_collect_ctrl #(
    parameter int          N_STARS    = 5,
    parameter logic [15:0] STAR_PTS   = 16'h0200,
    parameter int          SFX_CYCLES = 2_500_000
) (
    input  logic               sys_clk,
    input  logic               RST,
    input  logic [N_STARS-1:0] touch_star,
    output logic [15:0]        score_bcd,
    output logic [3:0]         star_count,
    output logic [2:0]         last_star_idx,
    output logic               collect_pulse,
    output logic               all_collected,
    output logic               sfx_on,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ADD    = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [15:0]        c_pts       = STAR_PTS;
    localparam logic [23:0]        c_sfx_load  = 24'(SFX_CYCLES);
    localparam logic [3:0]         c_n_stars   = 4'(N_STARS);
    localparam logic [N_STARS-1:0] c_one       = N_STARS'(1);
    localparam logic [15:0]        c_saturated = 16'h9999;

    logic [1:0]         r_state;
    logic [N_STARS-1:0] r_seen;
    logic [2:0]         r_idx;
    logic [15:0]        r_shadow;
    logic               r_carry;
    logic [1:0]         r_dig;
    logic [23:0]        r_sfx_cnt;

    logic [N_STARS-1:0] w_pending;
    logic [N_STARS-1:0] w_lsb_onehot;
    logic [2:0]         w_lsb_idx;
    logic [3:0]         w_pts_dig;
    logic [3:0]         w_sh_dig;
    logic [4:0]         w_sum;
    logic [4:0]         w_sum_adj;
    logic               w_gt9;
    logic [3:0]         w_new_dig;

    // Touches not yet accepted; the lowest one is isolated as a one-hot mask.
    assign w_pending    = touch_star & ~r_seen;
    assign w_lsb_onehot = w_pending & (~w_pending + c_one);

    // Binary index of the lowest pending star (scan downward so the lowest wins).
    always_comb begin
        w_lsb_idx = 3'd0;
        for (int i = N_STARS - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_lsb_idx = 3'(i);
            end
        end
    end

    // One BCD digit of shadow + STAR_PTS + carry, with decimal correction.
    assign w_pts_dig = c_pts[{r_dig, 2'b00} +: 4];
    assign w_sh_dig  = r_shadow[{r_dig, 2'b00} +: 4];
    assign w_sum     = {1'b0, w_sh_dig} + {1'b0, w_pts_dig} + {4'b0000, r_carry};
    assign w_sum_adj = w_sum - 5'd10;
    assign w_gt9     = (w_sum > 5'd9);
    assign w_new_dig = w_gt9 ? w_sum_adj[3:0] : w_sum[3:0];

    // Collection FSM: accept a star, add its points digit by digit, then commit.
    always_ff @(posedge sys_clk) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_seen        <= '0;
            r_idx         <= 3'd0;
            r_shadow      <= 16'h0000;
            r_carry       <= 1'b0;
            r_dig         <= 2'd0;
            score_bcd     <= 16'h0000;
            star_count    <= 4'd0;
            last_star_idx <= 3'd0;
            collect_pulse <= 1'b0;
        end else begin
            collect_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pending != '0) begin
                        r_idx    <= w_lsb_idx;
                        r_seen   <= r_seen | w_lsb_onehot;
                        r_shadow <= score_bcd;
                        r_carry  <= 1'b0;
                        r_dig    <= 2'd0;
                        r_state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_shadow[{r_dig, 2'b00} +: 4] <= w_new_dig;
                    r_carry <= w_gt9;
                    r_dig   <= r_dig + 2'd1;
                    if (r_dig == 2'd3) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // A carry out of the thousands digit means the score overflowed: clamp.
                    score_bcd     <= r_carry ? c_saturated : r_shadow;
                    star_count    <= star_count + 4'd1;
                    last_star_idx <= r_idx;
                    collect_pulse <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sound gate timer: reloaded by each commit strobe, so back-to-back pickups never gap.
    always_ff @(posedge sys_clk) begin
        if (RST) begin
            r_sfx_cnt <= 24'd0;
        end else if (collect_pulse) begin
            r_sfx_cnt <= c_sfx_load;
        end else if (r_sfx_cnt != 24'd0) begin
            r_sfx_cnt <= r_sfx_cnt - 24'd1;
        end
    end

    assign sfx_on        = (r_sfx_cnt != 24'd0);
    assign busy          = (r_state != S_IDLE);
    assign all_collected = (star_count == c_n_stars);

endmodule
`default_nettype wire

// File: tb/tb_star_collect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_star_collect_ctrl
//  Description : Self-checking bench for star_collect_ctrl. Instance A uses the
//                default scoring with a short sound gate; instance B uses eight
//                stars worth 1650 each to reach saturation and overlap the gate.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_star_collect_ctrl;

    typedef struct {
        int          cyc;
        logic [15:0] score;
        logic [3:0]  cnt;
        logic [2:0]  idx;
    } exp_t;

    typedef struct {
        logic [4:0]  touch;
        logic [15:0] score;
        logic [3:0]  cnt;
        logic [2:0]  last;
        logic        all;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  touch_a = 5'b0;
    logic [7:0]  touch_b = 8'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [15:0] score_a, score_b;
    logic [3:0]  cnt_a, cnt_b;
    logic [2:0]  last_a, last_b;
    logic        pulse_a, pulse_b, all_a, all_b, sfx_a, sfx_b, busy_a, busy_b;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [7:0]  seen_m[2];
    logic [15:0] score_m[2];
    int          cnt_m[2];
    vec_t        tbl[5];

    star_collect_ctrl #(.N_STARS(5), .STAR_PTS(16'h0200), .SFX_CYCLES(4)) u_dut_a (
        .sys_clk(clk), .RST(rst), .touch_star(touch_a),
        .score_bcd(score_a), .star_count(cnt_a), .last_star_idx(last_a),
        .collect_pulse(pulse_a), .all_collected(all_a), .sfx_on(sfx_a), .busy(busy_a)
    );

    star_collect_ctrl #(.N_STARS(8), .STAR_PTS(16'h1650), .SFX_CYCLES(8)) u_dut_b (
        .sys_clk(clk), .RST(rst), .touch_star(touch_b),
        .score_bcd(score_b), .star_count(cnt_b), .last_star_idx(last_b),
        .collect_pulse(pulse_b), .all_collected(all_b), .sfx_on(sfx_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bcd2int(input logic [15:0] b);
        int v = 0;
        for (int d = 3; d >= 0; d--) v = v * 10 + int'(b[d*4 +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] b = 16'h0;
        for (int d = 0; d < 4; d++) begin
            b[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset(input int sel);
        seen_m[sel]  = 8'h00;
        score_m[sel] = 16'h0000;
        cnt_m[sel]   = 0;
        if (sel == 0) q_a.delete(); else q_b.delete();
    endtask

    // Queue the expected commits for touches driven at cycle 'start'.
    task automatic push(input int sel, input logic [7:0] t, input int n,
                        input logic [15:0] pts, input int start, output int k);
        exp_t e;
        int   s;
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (t[i] && !seen_m[sel][i]) begin
                seen_m[sel][i] = 1'b1;
                s = bcd2int(score_m[sel]) + bcd2int(pts);
                if (s > 9999) s = 9999;
                score_m[sel] = int2bcd(s);
                cnt_m[sel]++;
                k++;
                e.cyc   = start + 6 * k;
                e.score = score_m[sel];
                e.cnt   = 4'(cnt_m[sel]);
                e.idx   = 3'(i);
                if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
            end
        end
    endtask

    task automatic mon(input int sel, input logic p, input logic [15:0] sc,
                       input logic [3:0] cn, input logic [2:0] ix);
        exp_t e;
        int   sz;
        sz = (sel == 0) ? q_a.size() : q_b.size();
        if (p) begin
            checks++;
            if (sz == 0) begin
                errors++;
                $display("FAIL pulse_%0d unexpected at cyc %0d score=%h cnt=%0d idx=%0d required no pulse",
                         sel, cyc, sc, cn, ix);
            end else begin
                if (sel == 0) e = q_a.pop_front(); else e = q_b.pop_front();
                if (e.cyc != cyc || e.score !== sc || e.cnt !== cn || e.idx !== ix) begin
                    errors++;
                    $display("FAIL pulse_%0d actual cyc=%0d score=%h cnt=%0d idx=%0d required cyc=%0d score=%h cnt=%0d idx=%0d",
                             sel, cyc, sc, cn, ix, e.cyc, e.score, e.cnt, e.idx);
                end
            end
        end else if (sz > 0) begin
            if (sel == 0) e = q_a[0]; else e = q_b[0];
            if (e.cyc == cyc) begin
                checks++;
                errors++;
                $display("FAIL pulse_%0d missing actual none required at cyc=%0d idx=%0d", sel, cyc, e.idx);
                if (sel == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
            end
        end
    endtask

    // Scoreboard side: compare every commit strobe against the queued expectation.
    always @(negedge clk) begin
        mon(0, pulse_a, score_a, cnt_a, last_a);
        mon(1, pulse_b, score_b, cnt_b, last_b);
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p;
        int s;
        int bad;

        tbl[0] = '{5'b00001, 16'h0200, 4'd1, 3'd0, 1'b0};
        tbl[1] = '{5'b00001, 16'h0200, 4'd1, 3'd0, 1'b0};
        tbl[2] = '{5'b10101, 16'h0600, 4'd3, 3'd4, 1'b0};
        tbl[3] = '{5'b11111, 16'h1000, 4'd5, 3'd3, 1'b1};
        tbl[4] = '{5'b11111, 16'h1000, 4'd5, 3'd3, 1'b1};
        model_reset(0);
        model_reset(1);

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_score_a", score_a, 16'h0);
        chk("rst_cnt_a", cnt_a, 4'd0);
        chk("rst_flags_a", {pulse_a, all_a, sfx_a, busy_a, last_a}, 7'h0);
        chk("rst_score_b", score_b, 16'h0);
        chk("rst_flags_b", {pulse_b, all_b, sfx_b, busy_b, cnt_b, last_b}, 11'h0);
        rst = 1'b0;

        // Table-driven steps on instance A.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            touch_a = tbl[i].touch;
            push(0, {3'b000, tbl[i].touch}, 5, 16'h0200, cyc, k);
            repeat (6 * k + 4) @(negedge clk);
            chk($sformatf("tbl%0d_score", i), score_a, tbl[i].score);
            chk($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].cnt);
            chk($sformatf("tbl%0d_last", i), last_a, tbl[i].last);
            chk($sformatf("tbl%0d_all", i), all_a, tbl[i].all);
            chk($sformatf("tbl%0d_busy", i), busy_a, 1'b0);
        end

        // Reset while adding (dig 2), then a still-high flag is counted again.
        @(negedge clk);
        rst = 1'b1;
        touch_a = 5'b00001;
        @(negedge clk);
        model_reset(0);
        rst = 1'b0;
        push(0, 8'h01, 5, 16'h0200, cyc, k);
        repeat (3) @(negedge clk);
        chk("mid_add_busy", busy_a, 1'b1);
        rst = 1'b1;
        model_reset(0);
        @(negedge clk);
        chk("mid_add_rst_outs",
            {score_a, cnt_a, last_a, pulse_a, all_a, sfx_a, busy_a}, 27'h0);
        rst = 1'b0;
        push(0, 8'h01, 5, 16'h0200, cyc, k);
        p = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (pulse_a) begin
                p = cyc;
                break;
            end
        end
        chk("recount_pulse_seen", (p >= 0), 1'b1);
        chk("sfx_a_at_pulse", sfx_a, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            chk($sformatf("sfx_a_p%0d", j), sfx_a, (j <= 4));
        end
        chk("recount_score", score_a, 16'h0200);

        // Instance B: seven stars at once, carry chain, saturation, gate retrigger.
        @(negedge clk);
        s = cyc;
        touch_b = 8'h7F;
        push(1, 8'h7F, 8, 16'h1650, cyc, k);
        bad = 0;
        for (int t = 1; t <= 51; t++) begin
            @(negedge clk);
            if (sfx_b !== ((cyc >= s + 7) && (cyc <= s + 50))) bad++;
        end
        chk("sfx_b_retrigger_bad_cycles", bad, 0);
        chk("sat_score_b", score_b, 16'h9999);
        chk("sat_cnt_b", cnt_b, 4'd7);
        chk("sat_last_b", last_b, 3'd6);
        chk("sat_all_b", all_b, 1'b0);
        @(negedge clk);
        touch_b = 8'hFF;
        push(1, 8'hFF, 8, 16'h1650, cyc, k);
        repeat (10) @(negedge clk);
        chk("full_score_b", score_b, 16'h9999);
        chk("full_cnt_b", cnt_b, 4'd8);
        chk("full_last_b", last_b, 3'd7);
        chk("full_all_b", all_b, 1'b1);
        repeat (12) @(negedge clk);
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
